// File: rtl/mcs4_pkg.sv
// mcs4_pkg: MCS-4 subcycle phase encoding and ROM I/O opcodes shared by the bus ports
package mcs4_pkg;
    typedef enum logic [3:0] {IDLE, A1, A2, A3, M1, M2, X1, X2, X3} phase_t;
    localparam logic [3:0] OPA_WRR = 4'h2;
    localparam logic [3:0] OPA_RDR = 4'hA;
    localparam logic [3:0] SUBCYCLES = 4'd8;
endpackage

// File: rtl/mcs4_phase_tracker.sv
// mcs4_phase_tracker: clk2 falling-edge tick, SYNC resync and current-subcycle register (phase_next is the post-tick value)
module mcs4_phase_tracker
    import mcs4_pkg::*;
(
    input  logic   sysclk,
    input  logic   poc,
    input  logic   clk2,
    input  logic   sync,
    output logic   tick,
    output phase_t phase,
    output phase_t phase_next
);
    logic clk2_q;
    assign tick = clk2_q & ~clk2;
    always_comb
        phase_next = !tick ? phase :
                     (sync || phase == phase_t'(SUBCYCLES)) ? A1 :
                     phase == IDLE ? IDLE : phase_t'(phase + 4'd1);
    always_ff @(posedge sysclk or posedge poc)
        if (poc) begin
            clk2_q <= 1'b0;
            phase <= IDLE;
        end else begin
            clk2_q <= clk2;
            phase <= phase_next;
        end
endmodule

// File: rtl/mcs4_rom_port.sv
// mcs4_rom_port: 4001 ROM bus emulation (address capture, req/ack instruction fetch, M1/M2 return, SRC/WRR/RDR I/O port)
module mcs4_rom_port
    import mcs4_pkg::*;
#(
    parameter logic [3:0] CHIP_ID = 4'h0
) (
    input  logic       sysclk,
    input  logic       poc,
    input  logic       clk2,
    input  logic       sync,
    input  logic       cmrom,
    input  logic [3:0] bus,
    output logic [3:0] data_in,
    output logic       data_oe,
    output logic       mem_req,
    output logic [7:0] mem_addr,
    input  logic       mem_ack,
    input  logic [7:0] mem_data,
    output logic       mem_late,
    input  logic [3:0] io_in,
    output logic [3:0] io_out
);
    logic       tick;
    phase_t     phase, ph_n;
    logic [7:0] addr, addr_n, inst, inst_n, maddr_n;
    logic [3:0] opa, opa_n, io_out_n, din_n;
    logic       sel, sel_n, got, got_n, io_cyc, io_cyc_n, src_sel, src_n, req_n, late_n, oe_n;

    mcs4_phase_tracker u_phase (
        .sysclk    (sysclk),
        .poc       (poc),
        .clk2      (clk2),
        .sync      (sync),
        .tick      (tick),
        .phase     (phase),
        .phase_next(ph_n)
    );

    always_comb begin
        addr_n = addr;
        sel_n = sel;
        got_n = got;
        inst_n = inst;
        req_n = mem_req;
        maddr_n = mem_addr;
        late_n = 1'b0;
        io_cyc_n = io_cyc;
        opa_n = opa;
        src_n = src_sel;
        io_out_n = io_out;
        if (mem_req && mem_ack) begin
            inst_n = mem_data;
            got_n = 1'b1;
            req_n = 1'b0;
        end
        if (tick && phase == A1) addr_n[3:0] = bus;
        if (tick && phase == A2) addr_n[7:4] = bus;
        if (tick && phase == A3) begin
            sel_n = cmrom && (bus == CHIP_ID);
            got_n = 1'b0;
            if (sel_n) begin
                req_n = 1'b1;
                maddr_n = addr;
            end
        end
        if (tick && phase == M1 && sel && !got_n) begin
            late_n = 1'b1;
            req_n = 1'b0;
            inst_n = 8'h00;
        end
        if (tick && phase == M2) begin
            io_cyc_n = cmrom;
            opa_n = bus;
        end
        if (tick && phase == X2 && cmrom && !io_cyc) src_n = (bus == CHIP_ID);
        if (tick && phase == X2 && io_cyc && opa == OPA_WRR && src_sel) io_out_n = bus;
        oe_n = ((ph_n == M1 || ph_n == M2) && sel_n && got_n) ||
               (ph_n == X2 && io_cyc_n && opa_n == OPA_RDR && src_n);
        din_n = !oe_n ? 4'h0 : ph_n == M1 ? inst_n[7:4] : ph_n == M2 ? inst_n[3:0] : io_in;
    end

    always_ff @(posedge sysclk or posedge poc)
        if (poc) begin
            addr <= 8'h00;
            sel <= 1'b0;
            got <= 1'b0;
            inst <= 8'h00;
            mem_req <= 1'b0;
            mem_addr <= 8'h00;
            mem_late <= 1'b0;
            io_cyc <= 1'b0;
            opa <= 4'h0;
            src_sel <= 1'b0;
            io_out <= 4'h0;
            data_oe <= 1'b0;
            data_in <= 4'h0;
        end else begin
            addr <= addr_n;
            sel <= sel_n;
            got <= got_n;
            inst <= inst_n;
            mem_req <= req_n;
            mem_addr <= maddr_n;
            mem_late <= late_n;
            io_cyc <= io_cyc_n;
            opa <= opa_n;
            src_sel <= src_n;
            io_out <= io_out_n;
            data_oe <= oe_n;
            data_in <= din_n;
        end
endmodule

// File: doc/mcs4_rom_port.md
# mcs4_rom_port

Emulates the bus side of one 4001 ROM chip for the i4004 core. It tracks the 8-subcycle instruction cycle from the core's phase clock and SYNC, and captures the 12-bit fetch address. When its chip is selected, it fetches an 8-bit instruction word from an external memory over a req/ack handshake and returns it on the core's data input during M1/M2. It also implements the 4001 4-bit I/O port (SRC/WRR/RDR).

## Interface
Parameters:
- CHIP_ID, 4'h0, chip number matched against address bits [11:8] and against the SRC chip nibble.

Ports:
- sysclk  in  1  system clock; only clock.
- poc  in  1  reset; asynchronous, active-high.
- clk2  in  1  core phase-2 clock, sysclk-synchronous level.
- sync  in  1  core SYNC; high during X3.
- cmrom  in  1  core CM-ROM.
- bus  in  4  resolved 4-bit data bus: core output ORed with all ROM drivers.
- data_in  out  4  nibble driven toward the core; 0 when not driving.
- data_oe  out  1  high while data_in carries a valid nibble.
- mem_req  out  1  instruction fetch request.
- mem_addr  out  8  low byte of the fetch address; stable while mem_req is high.
- mem_ack  in  1  memory has mem_data valid this cycle.
- mem_data  in  8  instruction word, OPR in [7:4], OPA in [3:0].
- mem_late  out  1  one-cycle pulse: ack not received by end of M1.
- io_in  in  4  I/O port input pins.
- io_out  out  4  I/O port output latch.

## Operation
- Tick: tick = clk2_q & ~clk2, where clk2_q is clk2 delayed one sysclk. All bus sampling and phase changes occur on tick.
- Phases: IDLE, A1, A2, A3, M1, M2, X1, X2, X3. The phase value names the subcycle that the tick ends.
- Phase transitions:
  - Reset state is IDLE.
  - From IDLE, a tick with sync=1 goes to A1.
  - Otherwise each tick advances one phase; X3 wraps to A1.
  - A tick with sync=1 in any phase other than X3 forces A1 (resync).
- A1 tick: addr[3:0] <= bus.
- A2 tick: addr[7:4] <= bus.
- A3 tick: sel <= cmrom & (bus == CHIP_ID). If selected, mem_req rises and mem_addr <= addr[7:0].
- Handshake:
  - mem_req stays high until mem_ack is sampled high.
  - In that sysclk cycle, the block captures mem_data into inst and drops mem_req the next cycle.
  - Only one request is outstanding per instruction cycle.
  - A new A3 select while a request is still pending keeps mem_req high and updates mem_addr.
- M1 phase (between the A3 and M1 ticks), if sel: data_oe=1, data_in=inst[7:4], once captured; before capture data_in=0 and data_oe=0.
- M2 phase, if sel and captured: data_oe=1, data_in=inst[3:0].
- M1 tick with sel and no ack yet: mem_late pulses; that cycle's instruction data is treated as 0; mem_req is dropped.
- M2 tick: io_cyc <= cmrom; opa <= bus.
- SRC: an X2 tick with cmrom=1 and io_cyc=0 sets src_sel <= (bus == CHIP_ID). src_sel persists until the next SRC.
- WRR (io_cyc, opa=4'h2, src_sel): the X2 tick latches io_out <= bus.
- RDR (io_cyc, opa=4'hA, src_sel): during the X2 phase, data_oe=1 and data_in=io_in, sampled live.
- All other phases: data_in=0, data_oe=0.

## Timing
- Reset values: data_in 0, data_oe 0, mem_req 0, mem_addr 0, mem_late 0, io_out 0; internal state is phase IDLE, sel 0, src_sel 0, io_cyc 0.
- mem_req is asserted the sysclk cycle after the A3 tick.
- data_in/data_oe change the sysclk cycle after the causing tick or ack; they are registered.
- Zero-wait memory (ack in the first req cycle): data is valid on the second sysclk after the A3 tick.
- poc mid-cycle clears everything immediately. The block stays silent until the next sync tick.
- A sync tick while in IDLE does not sample bus.

## Structure
- Package mcs4_pkg holds:
  - phase enum (IDLE..X3);
  - constants OPA_WRR=4'h2 and OPA_RDR=4'hA;
  - subcycle count 8.
- Sub-module mcs4_phase_tracker (clk2 edge detect, sync resync, phase register) is shared with a future 4002 RAM port.

## Test plan
- Reset, then drive sync and a cycle with bus A1..A3 = 5,3,0, cmrom=1 at A3, CHIP_ID=0 -> mem_req is high with mem_addr=8'h35. Ack with mem_data=8'hD7 -> data_in=4'hD in M1, 4'h7 in M2, each with data_oe=1.
- Same cycle with A3 nibble=1 -> mem_req never asserts and data_oe stays 0 for the whole cycle.
- Hold mem_ack low through M1 -> mem_late pulses once at the M1 tick, data_oe stays 0, and mem_req drops.
- SRC with chip nibble 0, then an I/O cycle with opa=2 and bus=4'h9 at X2 -> io_out=4'h9. Repeat with SRC chip 3 -> io_out unchanged.
- io_in=4'h6 with an RDR cycle after SRC chip 0 -> data_in=4'h6 and data_oe=1 during X2 only.
- Assert poc during M1 while driving -> all outputs are 0 at once. After release, the block stays idle until a sync tick, then resumes correctly.
